// File: rtl/aurora_pkg.sv
// Shared types and constants for the Aurora lane datapath.
// Block sync header encodings and the FSM state type live here.
package aurora_pkg;

    localparam int ENCODED_DATA_SIZE = 66;
    localparam int SLIP_OFFSET_SIZE  = 7;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT,
        SLIP_HOLD,
        LOCKED
    } block_sync_state_t;

    function automatic logic sync_header_ok(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/aurora_block_slip.sv
// Combinational 132-to-66 barrel selector: picks the block that starts
// slip_offset_i bits after the earliest bit of the two-word window.
module aurora_block_slip
    import aurora_pkg::*;
(
    input  logic [2*ENCODED_DATA_SIZE-1:0] window_i,
    input  logic [SLIP_OFFSET_SIZE-1:0]    slip_offset_i,
    output logic [ENCODED_DATA_SIZE-1:0]   block_o
);

    logic [2*ENCODED_DATA_SIZE-1:0] shifted;

    assign shifted = window_i << slip_offset_i;
    assign block_o = shifted[2*ENCODED_DATA_SIZE-1 -: ENCODED_DATA_SIZE];

endmodule

// File: rtl/aurora_rx_block_sync.sv
// 64b/66b receive block synchronizer for one Aurora lane: hunts for the
// sync-header boundary by bit slipping, holds lock and drops it on header errors.
module aurora_rx_block_sync
    import aurora_pkg::*;
#(
    parameter int LOCK_COUNT = 64,
    parameter int WINDOW     = 64,
    parameter int ERR_LIMIT  = 16,
    parameter int SLIP_WAIT  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx_valid,
    input  logic [ENCODED_DATA_SIZE-1:0] rx_data,
    output logic                         blk_valid,
    output logic [ENCODED_DATA_SIZE-1:0] blk_data,
    output logic                         blk_lock,
    output logic [SLIP_OFFSET_SIZE-1:0]  slip_offset,
    output logic                         sh_err
);

    localparam int SH_W   = $clog2(LOCK_COUNT + 1);
    localparam int BLK_W  = $clog2(WINDOW + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int HOLD_W = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_COUNT - 1);
    localparam logic [SH_W-1:0]   SH_ONE    = SH_W'(1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(WINDOW - 1);
    localparam logic [BLK_W-1:0]  BLK_ONE   = BLK_W'(1);
    localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_LIMIT - 1);
    localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLIP_WAIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    localparam logic [SLIP_OFFSET_SIZE-1:0] SLIP_MAX = SLIP_OFFSET_SIZE'(ENCODED_DATA_SIZE - 1);
    localparam logic [SLIP_OFFSET_SIZE-1:0] SLIP_ONE = SLIP_OFFSET_SIZE'(1);

    block_sync_state_t state_q;

    logic [ENCODED_DATA_SIZE-1:0] rx_prev_q;
    logic                         primed_q;
    logic [SH_W-1:0]              sh_cnt_q;
    logic [BLK_W-1:0]             blk_cnt_q;
    logic [ERR_W-1:0]             err_cnt_q;
    logic [HOLD_W-1:0]            hold_cnt_q;
    logic [SLIP_OFFSET_SIZE-1:0]  slip_offset_q;
    logic [SLIP_OFFSET_SIZE-1:0]  slip_offset_d;
    logic                         blk_valid_q;
    logic [ENCODED_DATA_SIZE-1:0] blk_data_q;
    logic                         blk_lock_q;
    logic                         sh_err_q;

    logic [2*ENCODED_DATA_SIZE-1:0] window;
    logic [ENCODED_DATA_SIZE-1:0]   aligned;
    logic                           hdr_ok;

    assign window = {rx_prev_q, rx_data};

    aurora_block_slip u_slip (
        .window_i      (window),
        .slip_offset_i (slip_offset_q),
        .block_o       (aligned)
    );

    assign hdr_ok        = sync_header_ok(aligned[ENCODED_DATA_SIZE-1 -: 2]);
    assign slip_offset_d = (slip_offset_q == SLIP_MAX) ? '0 : slip_offset_q + SLIP_ONE;

    // Everything advances only on an accepted word that completes a window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            rx_prev_q     <= '0;
            primed_q      <= 1'b0;
            sh_cnt_q      <= '0;
            blk_cnt_q     <= '0;
            err_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            slip_offset_q <= '0;
            blk_valid_q   <= 1'b0;
            blk_data_q    <= '0;
            blk_lock_q    <= 1'b0;
            sh_err_q      <= 1'b0;
        end else begin
            blk_valid_q <= 1'b0;
            sh_err_q    <= 1'b0;
            if (rx_valid) begin
                rx_prev_q <= rx_data;
                primed_q  <= 1'b1;
                if (primed_q) begin
                    blk_data_q  <= aligned;
                    blk_valid_q <= (state_q == LOCKED);
                    case (state_q)
                        HUNT: begin
                            if (hdr_ok) begin
                                if (sh_cnt_q == SH_LAST) begin
                                    state_q    <= LOCKED;
                                    blk_lock_q <= 1'b1;
                                    sh_cnt_q   <= '0;
                                    blk_cnt_q  <= '0;
                                    err_cnt_q  <= '0;
                                end else begin
                                    sh_cnt_q <= sh_cnt_q + SH_ONE;
                                end
                            end else begin
                                sh_err_q      <= 1'b1;
                                slip_offset_q <= slip_offset_d;
                                sh_cnt_q      <= '0;
                                hold_cnt_q    <= '0;
                                state_q       <= SLIP_HOLD;
                            end
                        end
                        SLIP_HOLD: begin
                            if (hold_cnt_q == HOLD_LAST) begin
                                hold_cnt_q <= '0;
                                state_q    <= HUNT;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + HOLD_ONE;
                            end
                        end
                        LOCKED: begin
                            sh_err_q <= !hdr_ok;
                            // Lock loss takes priority over a coincident window end.
                            if (!hdr_ok && (err_cnt_q == ERR_LAST)) begin
                                state_q       <= SLIP_HOLD;
                                blk_lock_q    <= 1'b0;
                                slip_offset_q <= slip_offset_d;
                                blk_cnt_q     <= '0;
                                err_cnt_q     <= '0;
                                hold_cnt_q    <= '0;
                            end else if (blk_cnt_q == BLK_LAST) begin
                                blk_cnt_q <= '0;
                                err_cnt_q <= '0;
                            end else begin
                                blk_cnt_q <= blk_cnt_q + BLK_ONE;
                                if (!hdr_ok) begin
                                    err_cnt_q <= err_cnt_q + ERR_ONE;
                                end
                            end
                        end
                        default: state_q <= HUNT;
                    endcase
                end
            end
        end
    end

    assign blk_valid   = blk_valid_q;
    assign blk_data    = blk_data_q;
    assign blk_lock    = blk_lock_q;
    assign slip_offset = slip_offset_q;
    assign sh_err      = sh_err_q;

endmodule

// File: tb/tb_aurora_rx_block_sync.sv
// Bench for aurora_rx_block_sync: a serial bit-stream transmitter with a
// configurable late shift feeds the DUT, and a stream-level model predicts outputs.
module tb_aurora_rx_block_sync;
    import aurora_pkg::*;

    localparam int LOCK_COUNT = 64;
    localparam int WINDOW     = 64;
    localparam int ERR_LIMIT  = 16;
    localparam int SLIP_WAIT  = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_valid = 1'b0;
    logic [65:0] rx_data  = '0;
    logic        blk_valid;
    logic [65:0] blk_data;
    logic        blk_lock;
    logic [6:0]  slip_offset;
    logic        sh_err;

    int checkCount = 0;
    int failCount  = 0;

    aurora_rx_block_sync #(
        .LOCK_COUNT (LOCK_COUNT),
        .WINDOW     (WINDOW),
        .ERR_LIMIT  (ERR_LIMIT),
        .SLIP_WAIT  (SLIP_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .blk_valid   (blk_valid),
        .blk_data    (blk_data),
        .blk_lock    (blk_lock),
        .slip_offset (slip_offset),
        .sh_err      (sh_err)
    );

    always #5 clk = ~clk;

    // Transmitter: blocks serialised earliest-bit-first into a bit queue.
    bit txBits[$];
    int txBlkIdx;
    bit badMask[0:4095];

    // Reference model state, expressed as stream-level bookkeeping.
    logic [65:0] mPrev;
    bit          mPrimed;
    int          mOff;
    bit          mLocked;
    int          mGoodRun;
    int          mIgnoreLeft;
    int          mWinBlocks;
    int          mWinErrs;
    bit          eValid;
    logic [65:0] eData;
    bit          eErr;

    function automatic void pushBlock();
        logic [65:0] b;
        logic [1:0]  h;
        h = (txBlkIdx % 2 == 1) ? SYNC_CTRL : SYNC_DATA;
        if (txBlkIdx < 4096 && badMask[txBlkIdx]) h = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        b = {h, $urandom, $urandom};
        for (int i = 65; i >= 0; i--) txBits.push_back(b[i]);
        txBlkIdx++;
    endfunction

    function automatic logic [65:0] nextWord();
        logic [65:0] w;
        while (txBits.size() < 66) pushBlock();
        for (int i = 65; i >= 0; i--) w[i] = txBits.pop_front();
        return w;
    endfunction

    function automatic void startStream(input int lateBits);
        txBits.delete();
        txBlkIdx = 0;
        for (int i = 0; i < 4096; i++) badMask[i] = 1'b0;
        for (int i = 0; i < lateBits; i++) txBits.push_back(1'($urandom_range(0, 1)));
    endfunction

    function automatic void modelReset();
        mPrev = '0; mPrimed = 0; mOff = 0; mLocked = 0; mGoodRun = 0;
        mIgnoreLeft = 0; mWinBlocks = 0; mWinErrs = 0;
        eValid = 0; eData = '0; eErr = 0;
    endfunction

    function automatic void modelClock(input bit v, input logic [65:0] w);
        logic [131:0] win;
        logic [65:0]  blk;
        bit           good;
        eValid = 0;
        eErr   = 0;
        if (!v) return;
        if (mPrimed) begin
            win = {mPrev, w};
            for (int b = 0; b < 66; b++) blk[65-b] = win[131-mOff-b];
            good   = blk[65] ^ blk[64];
            eData  = blk;
            eValid = mLocked;
            if (mIgnoreLeft > 0) begin
                mIgnoreLeft--;
            end else if (!mLocked) begin
                if (good) begin
                    mGoodRun++;
                    if (mGoodRun == LOCK_COUNT) begin
                        mLocked = 1; mGoodRun = 0; mWinBlocks = 0; mWinErrs = 0;
                    end
                end else begin
                    eErr = 1; mOff = (mOff + 1) % 66; mGoodRun = 0; mIgnoreLeft = SLIP_WAIT;
                end
            end else begin
                mWinBlocks++;
                if (!good) begin mWinErrs++; eErr = 1; end
                if (mWinErrs >= ERR_LIMIT) begin
                    mLocked = 0; mOff = (mOff + 1) % 66; mIgnoreLeft = SLIP_WAIT;
                    mWinBlocks = 0; mWinErrs = 0;
                end else if (mWinBlocks >= WINDOW) begin
                    mWinBlocks = 0; mWinErrs = 0;
                end
            end
        end
        mPrev   = w;
        mPrimed = 1;
    endfunction

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("blk_valid", 66'(blk_valid), 66'(eValid));
        check("blk_data", blk_data, eData);
        check("blk_lock", 66'(blk_lock), 66'(mLocked));
        check("slip_offset", 66'(slip_offset), 66'(mOff));
        check("sh_err", 66'(sh_err), 66'(eErr));
    endtask

    task automatic applyStimulus(input bit v, input logic [65:0] w);
        rx_valid = v;
        rx_data  = w;
        modelClock(v, w);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        rx_valid = 1'b0;
        modelReset();
        repeat (3) begin
            @(posedge clk);
            #1;
            rx_valid = ~rx_valid;
            rx_data  = {$urandom, $urandom, 2'b01};
        end
        check("rst_blk_valid", 66'(blk_valid), 66'(0));
        check("rst_blk_data", blk_data, 66'(0));
        check("rst_blk_lock", 66'(blk_lock), 66'(0));
        check("rst_slip", 66'(slip_offset), 66'(0));
        check("rst_sh_err", 66'(sh_err), 66'(0));
        @(negedge clk);
        rst_n = 1'b1;
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [65:0] words[$];
        logic [65:0] w;
        logic [6:0]  prevSlip;
        int          lockCycle;
        int          slip5Cycle;
        int          errPulses;
        bit          done;

        #1;
        // Aligned stream, then error bursts inside the first two lock windows.
        $display("[TB] aligned stream with error bursts");
        doReset();
        startStream(0);
        for (int j = 70; j <= 84; j++) badMask[j] = 1'b1;
        for (int j = 130; j <= 145; j++) badMask[j] = 1'b1;
        errPulses = 0;
        for (int c = 0; c <= 150; c++) begin
            w = nextWord();
            words.push_back(w);
            applyStimulus(1'b1, w);
            if (sh_err === 1'b1 && c <= 70) errPulses++;
            if (c == 0) check("first_word_quiet", blk_data, 66'(0));
            if (c == 1) check("first_block_w0", blk_data, words[0]);
            if (c == 63) check("lock_not_yet", 66'(blk_lock), 66'(0));
            if (c == 64) begin
                check("lock_at_64", 66'(blk_lock), 66'(1));
                check("no_valid_at_64", 66'(blk_valid), 66'(0));
            end
            if (c == 65) begin
                check("first_valid_65", 66'(blk_valid), 66'(1));
                check("first_data_w64", blk_data, words[64]);
            end
            if (c == 128) check("window1_end_locked", 66'(blk_lock), 66'(1));
            if (c == 145) check("fifteen_in_window2", 66'(blk_lock), 66'(1));
            if (c == 146) begin
                check("drop_on_16th", 66'(blk_lock), 66'(0));
                check("drop_slip", 66'(slip_offset), 66'(1));
                check("drop_block_valid", 66'(blk_valid), 66'(1));
                check("drop_sh_err", 66'(sh_err), 66'(1));
            end
        end
        check("aligned_no_sh_err", 66'(errPulses), 66'(0));

        // Stream five bits late: slips one bit at a time, then locks.
        $display("[TB] stream shifted 5 bits");
        doReset();
        startStream(5);
        prevSlip = '0; lockCycle = -1; slip5Cycle = -1;
        for (int c = 0; c < 1500 && lockCycle < 0; c++) begin
            applyStimulus(1'b1, nextWord());
            if (slip_offset !== prevSlip) begin
                check("slip_step", 66'(slip_offset), 66'(prevSlip + 7'd1));
                check("slip_with_sh_err", 66'(sh_err), 66'(1));
                prevSlip = slip_offset;
                if (slip_offset == 7'd5) slip5Cycle = c;
            end
            if (blk_lock === 1'b1) lockCycle = c;
        end
        check("late5_lock_seen", 66'(lockCycle >= 0), 66'(1));
        check("late5_offset", 66'(slip_offset), 66'(5));
        check("late5_lock_delay", 66'(lockCycle - slip5Cycle), 66'(SLIP_WAIT + LOCK_COUNT));

        // Stream 65 bits late: reaches the last offset, then a lock loss wraps to 0.
        $display("[TB] stream shifted 65 bits");
        doReset();
        startStream(65);
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            applyStimulus(1'b1, nextWord());
            if (blk_lock === 1'b1) done = 1;
        end
        check("late65_lock_seen", 66'(done), 66'(1));
        check("late65_offset", 66'(slip_offset), 66'(65));
        for (int j = txBlkIdx + 1; j < txBlkIdx + 33; j++) badMask[j] = 1'b1;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            applyStimulus(1'b1, nextWord());
            if (slip_offset !== 7'd65) done = 1;
        end
        check("wrap_seen", 66'(done), 66'(1));
        check("wrap_to_zero", 66'(slip_offset), 66'(0));
        check("wrap_unlocked", 66'(blk_lock), 66'(0));

        // Sparse rx_valid: lock counted in words, then an asynchronous reset mid-lock.
        $display("[TB] rx_valid every third cycle");
        doReset();
        startStream(0);
        words.delete();
        for (int k = 0; k < 70; k++) begin
            applyStimulus(1'b0, {$urandom, $urandom, 2'b11});
            applyStimulus(1'b0, {$urandom, $urandom, 2'b00});
            w = nextWord();
            words.push_back(w);
            applyStimulus(1'b1, w);
            if (k == 63) check("sparse_lock_not_yet", 66'(blk_lock), 66'(0));
            if (k == 64) check("sparse_lock", 66'(blk_lock), 66'(1));
            if (k == 65) begin
                check("sparse_first_valid", 66'(blk_valid), 66'(1));
                check("sparse_first_data", blk_data, words[64]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_lock", 66'(blk_lock), 66'(0));
        check("async_rst_slip", 66'(slip_offset), 66'(0));
        check("async_rst_data", blk_data, 66'(0));
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 66; k++) begin
            applyStimulus(1'b0, {$urandom, $urandom, 2'b10});
            applyStimulus(1'b0, {$urandom, $urandom, 2'b01});
            applyStimulus(1'b1, nextWord());
            if (k == 63) check("relock_not_yet", 66'(blk_lock), 66'(0));
            if (k == 64) check("relock_word65", 66'(blk_lock), 66'(1));
            if (k == 65) check("relock_valid_word66", 66'(blk_valid), 66'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
